page_xlate_tlb: RTL and testbench

- Parametrised address-translation unit; successor to the CPU's fixed single-PTE paging path.
- Translates CPU virtual addresses to physical addresses through an N-entry fully-associative TLB.
- On a TLB miss, walks a one-level page table at {BPR, VPN} in memory, then refills the TLB.
- Sits between the CPU's MAR/sequencer and the memory port; arbitration with CPU data accesses is external.

---
 rtl/page_xlate_tlb.sv | 234 +++++++++++++++++++++++
 tb/tb_page_xlate_tlb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/page_xlate_tlb.sv
// page_xlate_tlb -- virtual-to-physical translation through a small
// fully-associative TLB. A miss walks a one-level page table at {BPR, VPN}
// and refills the TLB round-robin.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   pg_en                 paging enable (snapshotted per request)
//   bpr_we, bpr_d         load base page register (also invalidates the TLB)
//   flush                 invalidate all TLB entries
//   req_valid/ready/vaddr translation request
//   rsp_valid/ready       translation response handshake
//   rsp_paddr, rsp_fault  physical address (0 on fault), PTE-invalid flag
//   mem_req, mem_addr     PTE read request, held until mem_ack
//   mem_ack, mem_rdata    PTE read completion and data
//
// Optional: define MMU_STATS_EN to add saturating hit_cnt, miss_cnt and
// fault_cnt outputs.

module page_xlate_tlb #(
    parameter int VA_W     = 6,
    parameter int PA_W     = 8,
    parameter int PG_OFF_W = 4,
    parameter int DATA_W   = 6,
    parameter int TLB_N    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pg_en,
    input  logic                          bpr_we,
    input  logic [PA_W-VA_W+PG_OFF_W-1:0] bpr_d,
    input  logic                          flush,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [VA_W-1:0]               req_vaddr,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [PA_W-1:0]               rsp_paddr,
    output logic                          rsp_fault,
    output logic                          mem_req,
    output logic [PA_W-1:0]               mem_addr,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata
`ifdef MMU_STATS_EN
    ,
    output logic [15:0]                   hit_cnt,
    output logic [15:0]                   miss_cnt,
    output logic [15:0]                   fault_cnt
`endif
);

    localparam int VPN_W = VA_W - PG_OFF_W;
    localparam int PPN_W = PA_W - PG_OFF_W;
    localparam int BPR_W = PA_W - VPN_W;
    localparam int PTR_W = (TLB_N > 1) ? $clog2(TLB_N) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, WALK, RESP} state_t;

    state_t state, state_nx;

    // request snapshot
    logic [VA_W-1:0]  va_q;
    logic             pg_q;
    logic [BPR_W-1:0] bpr_q;
    logic [BPR_W-1:0] bpr;

    // set by any flush/bpr_we between accept and mem_ack; blocks the refill
    logic             kill_q;

    // PTE captured on mem_ack; consumed one cycle later
    logic             pte_pend;
    logic             pte_ok_q;
    logic [PPN_W-1:0] pte_ppn_q;

    // TLB storage
    logic [TLB_N-1:0]            tlb_vld;
    logic [TLB_N-1:0][VPN_W-1:0] tlb_tag;
    logic [TLB_N-1:0][PPN_W-1:0] tlb_ppn;
    logic [PTR_W-1:0]            ptr;

    logic [VPN_W-1:0]    vpn_q;
    logic [PG_OFF_W-1:0] off_q;
    logic [TLB_N-1:0]    hit_vec;
    logic                hit;
    logic [PPN_W-1:0]    hit_ppn;
    logic                fill;
    logic                unused_rdata;

    assign vpn_q = va_q[VA_W-1:PG_OFF_W];
    assign off_q = va_q[PG_OFF_W-1:0];

    // Only the PPN field and the valid bit of a PTE carry meaning.
    assign unused_rdata = ^mem_rdata;

    for (genvar i = 0; i < TLB_N; i++) begin : g_cmp
        assign hit_vec[i] = tlb_vld[i] && (tlb_tag[i] == vpn_q);
    end

    assign hit = |hit_vec;

    // Tags are unique, so OR-ing the matching entries selects one PPN.
    always_comb begin
        hit_ppn = '0;
        for (int i = 0; i < TLB_N; i++)
            if (hit_vec[i]) hit_ppn = hit_ppn | tlb_ppn[i];
    end

    assign fill = (state == WALK) && pte_pend && pte_ok_q && !kill_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = LOOKUP;
            LOOKUP:  state_nx = (!pg_q || hit) ? RESP : WALK;
            WALK:    if (pte_pend) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);

    // ---------------- BPR ----------------
    always_ff @(posedge clk) begin
        if (rst)         bpr <= '0;
        else if (bpr_we) bpr <= bpr_d;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            va_q      <= '0;
            pg_q      <= 1'b0;
            bpr_q     <= '0;
            kill_q    <= 1'b0;
            pte_pend  <= 1'b0;
            pte_ok_q  <= 1'b0;
            pte_ppn_q <= '0;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_paddr <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
        end else begin
            // Set has priority so a flush in the accept cycle still counts.
            if (flush || bpr_we)
                kill_q <= 1'b1;
            else if (state == IDLE && req_valid)
                kill_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        va_q  <= req_vaddr;
                        pg_q  <= pg_en;
                        bpr_q <= bpr;       // pre-write value if bpr_we coincides
                    end
                end
                LOOKUP: begin
                    if (!pg_q) begin
                        rsp_paddr <= PA_W'(va_q);
                        rsp_fault <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else if (hit) begin
                        rsp_paddr <= {hit_ppn, off_q};
                        rsp_fault <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= {bpr_q, vpn_q};
                    end
                end
                WALK: begin
                    if (pte_pend) begin
                        pte_pend  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_fault <= !pte_ok_q;
                        rsp_paddr <= pte_ok_q ? {pte_ppn_q, off_q} : '0;
                    end else if (mem_req && mem_ack) begin
                        mem_req   <= 1'b0;
                        pte_pend  <= 1'b1;
                        pte_ok_q  <= mem_rdata[0];
                        pte_ppn_q <= mem_rdata[DATA_W-1 -: PPN_W];
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ---------------- TLB ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tlb_vld <= '0;
            ptr     <= '0;
        end else begin
            if (fill) begin
                tlb_tag[ptr] <= vpn_q;
                tlb_ppn[ptr] <= pte_ppn_q;
                tlb_vld[ptr] <= 1'b1;
                ptr          <= (ptr == PTR_W'(TLB_N - 1)) ? '0 : ptr + PTR_W'(1);
            end
            // Invalidation overrides a coincident fill.
            if (flush || bpr_we) tlb_vld <= '0;
        end
    end

`ifdef MMU_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            fault_cnt <= '0;
        end else begin
            if (state == LOOKUP && pg_q && hit && hit_cnt != 16'hFFFF)
                hit_cnt <= hit_cnt + 16'd1;
            if (state == LOOKUP && pg_q && !hit && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;
            if (state == WALK && !pte_pend && mem_req && mem_ack && !mem_rdata[0]
                && fault_cnt != 16'hFFFF)
                fault_cnt <= fault_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_page_xlate_tlb.sv
// Scoreboard bench for page_xlate_tlb (default parameters, TLB_N=2).
// Stimulus pushes expected {fault, paddr} into a queue; a monitor pops on
// each rsp_valid&rsp_ready and compares.

module tb_page_xlate_tlb;

    logic       clk = 1'b0;
    logic       rst, pg_en, bpr_we, flush, req_valid, rsp_ready, mem_ack;
    logic [5:0] bpr_d, req_vaddr, mem_rdata;
    logic       req_ready, rsp_valid, rsp_fault, mem_req;
    logic [7:0] rsp_paddr, mem_addr;
`ifdef MMU_STATS_EN
    logic [15:0] hit_cnt, miss_cnt, fault_cnt;
`endif

    page_xlate_tlb dut (
        .clk(clk), .rst(rst), .pg_en(pg_en), .bpr_we(bpr_we), .bpr_d(bpr_d),
        .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
        .req_vaddr(req_vaddr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_paddr(rsp_paddr), .rsp_fault(rsp_fault), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef MMU_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .fault_cnt(fault_cnt)
`endif
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [8:0] sb_q[$];

    bit         flush_in_walk = 0;
    bit         bpr_at_accept = 0;
    logic [5:0] bpr_new       = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // monitor
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL rsp_unexpected: got paddr %0h with no expected response", rsp_paddr);
            end else begin
                logic [8:0] e;
                e = sb_q.pop_front();
                check("rsp_paddr", {24'd0, rsp_paddr}, {24'd0, e[7:0]});
                check("rsp_fault", {31'd0, rsp_fault}, {31'd0, e[8]});
            end
        end
    end

    // One request. walk=1 expects a PTE read at maddr answered with pte.
    task automatic do_req(input logic [5:0] va, input bit walk, input logic [7:0] maddr,
                          input logic [5:0] pte, input logic [7:0] exp_pa,
                          input bit exp_f, input int hold);
        int n;
        sb_q.push_back({exp_f, exp_pa});
        rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_vaddr = va;
        if (bpr_at_accept) begin bpr_we = 1'b1; bpr_d = bpr_new; end
        @(posedge clk); #1;                       // accept edge
        req_valid = 1'b0;
        bpr_we    = 1'b0;
        check("lat_early", {31'd0, rsp_valid}, 32'd0);
        if (walk) begin
            n = 0;
            while (!mem_req && n < 20) begin @(posedge clk); #1; n++; end
            check("mem_req", {31'd0, mem_req}, 32'd1);
            check("mem_addr", {24'd0, mem_addr}, {24'd0, maddr});
            if (flush_in_walk) flush = 1'b1;
            @(posedge clk); #1;
            flush     = 1'b0;
            check("mem_req_held", {31'd0, mem_req}, 32'd1);
            mem_ack   = 1'b1;
            mem_rdata = pte;
            @(posedge clk); #1;                   // end of ack cycle
            mem_ack = 1'b0;
            check("mem_req_drop", {31'd0, mem_req}, 32'd0);
            check("miss_lat_early", {31'd0, rsp_valid}, 32'd0);
            @(posedge clk); #1;
            check("miss_lat", {31'd0, rsp_valid}, 32'd1);
        end else begin
            check("no_mem_req0", {31'd0, mem_req}, 32'd0);
            @(posedge clk); #1;
            check("hit_lat", {31'd0, rsp_valid}, 32'd1);
            check("no_mem_req1", {31'd0, mem_req}, 32'd0);
        end
        if (hold > 0) begin
            logic [7:0] pa;
            pa = rsp_paddr;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                check("bp_valid", {31'd0, rsp_valid}, 32'd1);
                check("bp_paddr", {24'd0, rsp_paddr}, {24'd0, pa});
                check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            end
            rsp_ready = 1'b1;
        end
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        check("back_to_idle", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pg_en = 1'b0; bpr_we = 1'b0; bpr_d = '0; flush = 1'b0;
        req_valid = 1'b0; req_vaddr = '0; rsp_ready = 1'b1;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
        check("rst_rsp_paddr", {24'd0, rsp_paddr}, 32'd0);
        check("rst_mem_req",   {31'd0, mem_req},   32'd0);
        check("rst_mem_addr",  {24'd0, mem_addr},  32'd0);

        bpr_we = 1'b1; bpr_d = 6'h05;
        @(posedge clk); #1;
        bpr_we = 1'b0; pg_en = 1'b1;

        // walk then hit
        do_req(6'h1A, 1, 8'h15, 6'h31, 8'hCA, 0, 0);
        do_req(6'h13, 0, 8'h00, 6'h00, 8'hC3, 0, 0);
        // fault, and no fill: walks again
        do_req(6'h25, 1, 8'h16, 6'h30, 8'h00, 1, 0);
        do_req(6'h25, 1, 8'h16, 6'h30, 8'h00, 1, 0);
        // replacement: VPN2 -> entry1, VPN3 evicts VPN1 in entry0
        do_req(6'h27, 1, 8'h16, 6'h1D, 8'h77, 0, 0);
        do_req(6'h3C, 1, 8'h17, 6'h25, 8'h9C, 0, 0);
        do_req(6'h20, 0, 8'h00, 6'h00, 8'h70, 0, 0);
        do_req(6'h10, 1, 8'h15, 6'h31, 8'hC0, 0, 0);
        // flush mid-walk: response delivered, no fill
        flush_in_walk = 1;
        do_req(6'h05, 1, 8'h14, 6'h3D, 8'hF5, 0, 0);
        flush_in_walk = 0;
        do_req(6'h05, 1, 8'h14, 6'h3D, 8'hF5, 0, 0);
        // backpressure on a hit
        do_req(6'h0A, 0, 8'h00, 6'h00, 8'hFA, 0, 5);
        // bpr_we with accept: old BPR used, fill suppressed, new BPR afterwards
        bpr_at_accept = 1; bpr_new = 6'h3F;
        do_req(6'h2C, 1, 8'h16, 6'h31, 8'hCC, 0, 0);
        bpr_at_accept = 0;
        do_req(6'h2C, 1, 8'hFE, 6'h11, 8'h4C, 0, 0);
        do_req(6'h2C, 0, 8'h00, 6'h00, 8'h4C, 0, 0);
        // paging off
        pg_en = 1'b0;
        do_req(6'h3F, 0, 8'h00, 6'h00, 8'h3F, 0, 0);
        pg_en = 1'b1;

        // reset mid-walk
        req_valid = 1'b1; req_vaddr = 6'h30;
        @(posedge clk); #1;
        req_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (!mem_req && n < 20) begin @(posedge clk); #1; n++; end
            check("rmw_mem_req", {31'd0, mem_req}, 32'd1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rmw_mem_req_drop", {31'd0, mem_req}, 32'd0);
        check("rmw_req_ready", {31'd0, req_ready}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 6'h31;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rmw_no_rsp", {31'd0, rsp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        // reset cleared TLB and BPR: walk at {0, VPN2}
        do_req(6'h2C, 1, 8'h02, 6'h31, 8'hCC, 0, 0);

        repeat (3) @(posedge clk);
        #1 check("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
